alu_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit, the sequential companion to the single-cycle ALU.

---
 rtl/alu_muldiv.sv | 135 +++++++++++++
 tb/tb_alu_muldiv.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: one product/quotient bit per cycle,
// valid/ready request side, single-cycle o_valid pulse on completion.
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIN} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opa_q, opb_q;  // raw operands in PREP, magnitudes afterwards
  logic [XLEN-1:0] acc_q, lo_q;   // product {hi,lo} or {remainder,quotient}
  logic [XLEN-1:0] res_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;

  logic                is_div, is_rem, sgn_a, sgn_b, neg_a, neg_b;
  logic                div0, ovf, ge;
  logic [XLEN-1:0]     mag_a, mag_b, quo_fx, rem_fx, fin_res;
  logic [2*XLEN-1:0]   prod, prod_nx, prod_fx;
  logic [XLEN:0]       rem_sh, diff;

  always_comb begin
    is_div  = op_q[2];
    is_rem  = op_q[2] & op_q[1];
    sgn_a   = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    sgn_b   = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    neg_a   = sgn_a & opa_q[XLEN-1];
    neg_b   = sgn_b & opb_q[XLEN-1];
    mag_a   = neg_a ? -opa_q : opa_q;
    mag_b   = neg_b ? -opb_q : opb_q;
    div0    = is_div && (opb_q == '0);
    ovf     = is_div && sgn_b && (opa_q == MOST_NEG) && (&opb_q);

    // Multiply: MSB-first shift-add; multiplier bits consumed from opb_q top.
    prod    = {acc_q, lo_q};
    prod_nx = {prod[2*XLEN-2:0], 1'b0} + (opb_q[XLEN-1] ? {{XLEN{1'b0}}, opa_q} : '0);

    // Divide: restoring step, dividend bits shifted out of lo_q as quotient bits shift in.
    rem_sh  = {acc_q, lo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, opb_q};
    ge      = ~diff[XLEN];

    prod_fx = neg_q ? -prod : prod;
    quo_fx  = neg_q ? -lo_q : lo_q;
    rem_fx  = neg_q ? -acc_q : acc_q;
    if (!op_q[2])
      fin_res = (op_q == 3'd0) ? prod_fx[XLEN-1:0] : prod_fx[2*XLEN-1:XLEN];
    else
      fin_res = op_q[1] ? rem_fx : quo_fx;
  end

  // A flush or reset arriving in FIN must kill the pulse in that very cycle.
  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_FIN) && !i_flush && !i_rst;
  assign o_result = o_valid ? fin_res : res_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else if (i_flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (i_valid) begin
          op_q    <= i_md_op;
          opa_q   <= i_operand_a;
          opb_q   <= i_operand_b;
          state_q <= S_PREP;
        end
        S_PREP: begin
          cnt_q <= CNT_INIT;
          opa_q <= mag_a;
          opb_q <= mag_b;
          acc_q <= '0;
          lo_q  <= is_div ? mag_a : '0;
          neg_q <= is_rem ? neg_a : (neg_a ^ neg_b);
          state_q <= S_CALC;
          // Corner results are parked where FIN's selection will pick them up unmodified.
          if (div0) begin
            neg_q   <= 1'b0;
            acc_q   <= opa_q;
            lo_q    <= '1;
            state_q <= S_FIN;
          end else if (ovf) begin
            neg_q   <= 1'b0;
            acc_q   <= '0;
            lo_q    <= opa_q;
            state_q <= S_FIN;
          end
        end
        S_CALC: begin
          if (is_div) begin
            acc_q <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            lo_q  <= {lo_q[XLEN-2:0], ge};
          end else begin
            {acc_q, lo_q} <= prod_nx;
            opb_q <= {opb_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == '0) state_q <= S_FIN;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_FIN: begin
          res_q   <= fin_res;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed vector table, flush/reset sequences and a
// back-to-back random run, all results checked through a model-fed scoreboard.
module tb_alu_muldiv;
  localparam int XLEN = 32;

  logic        i_clk = 1'b0, i_rst = 1'b1, i_flush = 1'b0, i_valid = 1'b0;
  logic [2:0]  i_md_op = '0;
  logic [31:0] i_operand_a = '0, i_operand_b = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_result;

  always #5 i_clk = ~i_clk;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_md_op(i_md_op), .i_operand_a(i_operand_a),
    .i_operand_b(i_operand_b), .o_valid(o_valid), .o_result(o_result)
  );

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
  typedef struct { logic [31:0] exp; int acc; bit corner; } sb_t;

  vec_t vt[$];
  sb_t  sbq[$];
  int   n_chk = 0, n_err = 0, cyc = 0, prev_acc = 0;
  bit   b2b = 0, have_prev = 0, prev_corner = 0, prev_v = 0;
  logic [31:0] last, r;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [31:0] sq;
    up = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: return up[31:0];
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        sq = $signed(a) / $signed(b); return sq;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        sq = $signed(a) % $signed(b); return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_corner(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard: push at the negedge preceding an accept edge, pop on o_valid.
  always @(negedge i_clk) begin
    sb_t e;
    if (o_valid === 1'b1) begin
      chk("ready_low_during_valid", {31'b0, o_ready}, 32'd0);
      chk("valid_not_consecutive", {31'b0, prev_v}, 32'd0);
      if (sbq.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_valid: got result %h with no op outstanding", o_result);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", o_result, e.exp);
        chk("sb_latency", 32'(cyc - e.acc), 32'(e.corner ? 2 : XLEN + 2));
      end
    end
    prev_v = (o_valid === 1'b1);
    if (i_rst || i_flush) sbq.delete();
    else if (i_valid && o_ready === 1'b1) begin
      e.exp = model(i_md_op, i_operand_a, i_operand_b);
      e.acc = cyc;
      e.corner = is_corner(i_md_op, i_operand_a, i_operand_b);
      if (b2b && have_prev)
        chk("accept_spacing", 32'(cyc - prev_acc), 32'(prev_corner ? 3 : XLEN + 3));
      prev_acc = cyc; prev_corner = e.corner; have_prev = 1;
      sbq.push_back(e);
    end
  end

  task automatic wait_ready();
    bit got = 0;
    for (int k = 0; k < XLEN + 10 && !got; k++) begin
      @(negedge i_clk);
      got = (o_ready === 1'b1);
    end
    if (!got) begin n_chk++; n_err++; $display("FAIL wait_ready: timeout, o_ready %b", o_ready); end
  endtask

  // Returns just after the accept edge (unit in PREP).
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    @(posedge i_clk); #1;
    i_md_op = op; i_operand_a = a; i_operand_b = b; i_valid = 1'b1;
    wait_ready();
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_res(output logic [31:0] res);
    res = '0;
    for (int k = 0; k < XLEN + 10; k++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) begin res = o_result; return; end
    end
    n_chk++; n_err++;
    $display("FAIL wait_valid: timeout, o_valid %b", o_valid);
  endtask

  task automatic rand_ops();
    logic [2:0] op;
    logic [31:0] a, b;
    op = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: a = 32'h80000000;
      1: a = 32'($urandom_range(0, 20));
      default: a = $urandom;
    endcase
    case ($urandom_range(0, 7))
      0: b = 32'h0;
      1: b = 32'hFFFFFFFF;
      2: b = 32'($urandom_range(1, 20));
      default: b = $urandom;
    endcase
    i_md_op = op; i_operand_a = a; i_operand_b = b;
  endtask

  initial begin
    vt.push_back('{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB});
    vt.push_back('{3'd1, 32'h80000000,   32'h80000000, 32'h40000000});
    vt.push_back('{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE});
    vt.push_back('{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF});
    vt.push_back('{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD});
    vt.push_back('{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF});
    vt.push_back('{3'd5, 32'd100,        32'd7,        32'd14});
    vt.push_back('{3'd7, 32'd100,        32'd7,        32'd2});
    vt.push_back('{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF});
    vt.push_back('{3'd6, 32'd5,          32'd0,        32'd5});
    vt.push_back('{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000});
    vt.push_back('{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0});
    vt.push_back('{3'd0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000});
    vt.push_back('{3'd4, 32'h80000000,   32'd1,        32'h80000000});
    vt.push_back('{3'd5, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF});
    vt.push_back('{3'd7, 32'd9,          32'd0,        32'd9});

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset_ready", {31'b0, o_ready}, 32'd1);
    chk("reset_valid", {31'b0, o_valid}, 32'd0);
    chk("reset_result", o_result, 32'd0);

    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      wait_res(r);
      chk($sformatf("vec%0d", i), r, vt[i].exp);
      last = r;
    end

    // Flush at CALC cycle 10.
    issue(3'd3, 32'hDEADBEEF, 32'h12345678);
    repeat (10) @(posedge i_clk);
    #1 i_flush = 1'b1;
    @(posedge i_clk); #1 i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_calc_ready", {31'b0, o_ready}, 32'd1);
    chk("flush_calc_valid", {31'b0, o_valid}, 32'd0);
    chk("flush_calc_result_held", o_result, last);
    repeat (XLEN + 5) @(negedge i_clk);
    issue(3'd0, 32'd3, 32'd4);
    wait_res(r);
    chk("mul_after_flush", r, 32'd12);
    last = r;

    // Flush in FIN of a corner-case op.
    issue(3'd5, 32'd5, 32'd0);
    @(posedge i_clk); #1 i_flush = 1'b1;
    @(negedge i_clk);
    chk("flush_fin_valid", {31'b0, o_valid}, 32'd0);
    chk("flush_fin_result", o_result, last);
    @(posedge i_clk); #1 i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_fin_ready", {31'b0, o_ready}, 32'd1);
    chk("flush_fin_result_held", o_result, last);

    // Flush beats a same-cycle request.
    @(posedge i_clk); #1;
    i_md_op = 3'd0; i_operand_a = 32'd1; i_operand_b = 32'd1; i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1 i_valid = 1'b0; i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_beats_accept", {31'b0, o_ready}, 32'd1);
    repeat (5) @(negedge i_clk);

    // Reset at CALC cycle 5.
    issue(3'd4, 32'd1000, 32'd7);
    repeat (5) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_mid_result", o_result, 32'd0);
    chk("rst_mid_ready", {31'b0, o_ready}, 32'd1);
    issue(3'd7, 32'd100, 32'd7);
    wait_res(r);
    chk("remu_after_rst", r, 32'd2);

    // Back-to-back random ops with i_valid held high.
    @(posedge i_clk); #1;
    have_prev = 0; b2b = 1;
    rand_ops();
    i_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      wait_ready();
      @(posedge i_clk); #1;
      rand_ops();
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    b2b = 0;
    repeat (XLEN + 6) @(negedge i_clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
